// File: rtl/layer_arbiter.sv
// Frame-synchronous priority arbiter: picks one of LAYERS sprite layers per pixel from a
// programmable rank table/mask (swapped in at frame start) and tracks player overlap per frame.
// One-cycle pixel latency; no backpressure, config ports accept a write every cycle.
module layer_arbiter #(
   parameter int LAYERS = 4,
   parameter int IDXW   = $clog2(LAYERS)
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                startOfFrame,
   input  logic [LAYERS-1:0]   layerDR,
   input  logic [8*LAYERS-1:0] layerRGB,
   input  logic [7:0]          backGroundRGB,
   input  logic                cfgWrite,
   input  logic [IDXW-1:0]     cfgRank,
   input  logic [IDXW-1:0]     cfgLayer,
   input  logic                cfgMaskWrite,
   input  logic [LAYERS-1:0]   cfgMask,
   output logic [7:0]          RGBOut,
   output logic                winnerValid,
   output logic [IDXW-1:0]     winnerIdx,
   output logic [LAYERS-1:0]   collisionFlags,
   output logic                collisionValid
);

   logic [IDXW-1:0]   pend_rank [LAYERS];
   logic [IDXW-1:0]   act_rank  [LAYERS];
   logic [LAYERS-1:0] pend_mask;
   logic [LAYERS-1:0] act_mask;
   logic [LAYERS-1:0] acc;
   logic [LAYERS-1:0] hit;
   logic [7:0]        rgb_arr [LAYERS];
   logic              found;
   logic [IDXW-1:0]   win;

   always_comb begin
      for (int k = 0; k < LAYERS; k++)
         rgb_arr[k] = layerRGB[8*k +: 8];
   end

   // Out-of-range ranks/layers (non power-of-two LAYERS) are dropped so the table stays valid.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int r = 0; r < LAYERS; r++) begin
            pend_rank[r] <= IDXW'(r);
            act_rank[r]  <= IDXW'(r);
         end
         pend_mask <= '1;
         act_mask  <= '1;
      end else begin
         if (cfgWrite && (int'(cfgRank) < LAYERS) && (int'(cfgLayer) < LAYERS))
            pend_rank[cfgRank] <= cfgLayer;
         if (cfgMaskWrite)
            pend_mask <= cfgMask;
         if (startOfFrame) begin
            act_rank <= pend_rank;
            act_mask <= pend_mask;
         end
      end
   end

   // First matching rank wins, so duplicate entries later in the table are shadowed.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int r = 0; r < LAYERS; r++) begin
         if (!found && layerDR[act_rank[r]] && act_mask[act_rank[r]]) begin
            found = 1'b1;
            win   = act_rank[r];
         end
      end
      hit    = {LAYERS{layerDR[0] & act_mask[0]}} & layerDR & act_mask;
      hit[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         RGBOut         <= '0;
         winnerValid    <= 1'b0;
         winnerIdx      <= '0;
         acc            <= '0;
         collisionFlags <= '0;
         collisionValid <= 1'b0;
      end else begin
         RGBOut      <= found ? rgb_arr[win] : backGroundRGB;
         winnerValid <= found;
         winnerIdx   <= win;
         if (startOfFrame) begin
            collisionFlags <= acc;
            acc            <= hit;
            collisionValid <= 1'b1;
         end else begin
            acc            <= acc | hit;
            collisionValid <= 1'b0;
         end
      end
   end

endmodule
